// File: rtl/aes_pkg.sv
// Shared AES-128 types and the GF(2^8) helpers used by the byte-level round blocks.
package aes_pkg;
   localparam int AES_ROUNDS = 10;

   typedef logic [3:0]   rnd_t;
   typedef logic [127:0] block_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as the field inverse (a^254, with 0 mapping to 0) followed by the affine transform
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = gmul(a, a);
      inv = sq;
      for (int i = 0; i < 6; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction
endpackage

// File: rtl/aes_128_seq_if.sv
// Plaintext/key input handshake and ciphertext output handshake of the iterative AES engine.
interface aes_128_seq_if;
   import aes_pkg::*;

   logic   in_valid;
   logic   in_ready;
   block_t in_bus;
   block_t key;
   logic   out_valid;
   logic   out_ready;
   block_t out_bus;
   logic   busy;

   modport master (output in_valid, in_bus, key, out_ready,
                   input  in_ready, out_valid, out_bus, busy);
   modport slave  (input  in_valid, in_bus, key, out_ready,
                   output in_ready, out_valid, out_bus, busy);
endinterface

// File: rtl/aes_round.sv
// One AES cipher round; the final round skips MixColumns.
module aes_round
   import aes_pkg::*;
(
   input  block_t in_bus,
   input  block_t round_key,
   input  logic   last,
   output block_t out_bus
);
   block_t sb;
   block_t sr;
   block_t mc;

   sub_bytes   u_sub_bytes   (.in_bus(in_bus), .out_bus(sb));
   shift_rows  u_shift_rows  (.in_bus(sb),     .out_bus(sr));
   mix_columns u_mix_columns (.in_bus(sr),     .out_bus(mc));

   assign out_bus = (last ? sr : mc) ^ round_key;
endmodule

// File: rtl/key_expansion.sv
// Expands a 128-bit cipher key into all eleven round keys; round_keys[0] is the key itself.
module key_expansion
   import aes_pkg::*;
(
   input  block_t                 key,
   output block_t [AES_ROUNDS:0]  round_keys
);
   localparam int NW = 4 * (AES_ROUNDS + 1);

   logic [31:0] w [NW];
   logic [31:0] temp;
   logic [7:0]  rcon;

   always_comb begin
      rcon       = 8'h01;
      temp       = '0;
      round_keys = '0;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < NW; i++) begin
         temp = w[i-1];
         if (i % 4 == 0) begin
            temp = {sbox(temp[23:16]), sbox(temp[15:8]), sbox(temp[7:0]), sbox(temp[31:24])}
                   ^ {rcon, 24'h000000};
            rcon = xtime(rcon);
         end
         w[i] = w[i-4] ^ temp;
      end
      for (int r = 0; r <= AES_ROUNDS; r++) begin
         round_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   end
endmodule

// File: rtl/mix_columns.sv
// Multiplies each state column by the fixed MixColumns polynomial over GF(2^8).
module mix_columns
   import aes_pkg::*;
(
   input  block_t in_bus,
   output block_t out_bus
);
   logic [7:0] a0, a1, a2, a3;

   always_comb begin
      out_bus = '0;
      a0 = '0;
      a1 = '0;
      a2 = '0;
      a3 = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = in_bus[127 - 32*c -: 8];
         a1 = in_bus[119 - 32*c -: 8];
         a2 = in_bus[111 - 32*c -: 8];
         a3 = in_bus[103 - 32*c -: 8];
         out_bus[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         out_bus[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         out_bus[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         out_bus[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
   end
endmodule

// File: rtl/shift_rows.sv
// Cyclically shifts row r of the column-major state left by r bytes.
module shift_rows
   import aes_pkg::*;
(
   input  block_t in_bus,
   output block_t out_bus
);
   always_comb begin
      out_bus = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            out_bus[127 - 8*(4*c + r) -: 8] = in_bus[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
   end
endmodule

// File: rtl/sub_bytes.sv
// Applies the AES S-box to each of the 16 state bytes.
module sub_bytes
   import aes_pkg::*;
(
   input  block_t in_bus,
   output block_t out_bus
);
   always_comb begin
      out_bus = '0;
      for (int i = 0; i < 16; i++) out_bus[8*i +: 8] = sbox(in_bus[8*i +: 8]);
   end
endmodule

// File: rtl/aes_128_seq.sv
// Iterative AES-128 encryptor: initial AddRoundKey on accept, then one round per clock for ten clocks.
module aes_128_seq
   import aes_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   aes_128_seq_if.slave  bus
);
   seq_state_t            state;
   rnd_t                  rnd;
   block_t                st;
   block_t                key_reg;
   block_t                round_key;
   block_t                round_out;
   block_t [AES_ROUNDS:0] round_keys;
   logic                  accept;
   logic                  last;

   key_expansion u_key_expansion (.key(key_reg), .round_keys(round_keys));

   assign round_key = round_keys[rnd];
   assign last      = (rnd == rnd_t'(AES_ROUNDS));

   aes_round u_aes_round (.in_bus(st), .round_key(round_key), .last(last), .out_bus(round_out));

   // A new pair may enter in DONE only while the finished ciphertext leaves on the same edge
   assign bus.in_ready  = !rst && (state == IDLE || (state == DONE && bus.out_ready));
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == RUN);
   assign bus.out_bus   = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rnd     <= '0;
         st      <= '0;
         key_reg <= '0;
      end else if (accept) begin
         key_reg <= bus.key;
         st      <= bus.in_bus ^ bus.key;
         rnd     <= rnd_t'(1);
         state   <= RUN;
      end else begin
         case (state)
            RUN: begin
               st <= round_out;
               if (last) begin
                  rnd   <= '0;
                  state <= DONE;
               end else begin
                  rnd <= rnd + rnd_t'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= state;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_128_seq.sv
// Scenario bench for aes_128_seq: FIPS-197 vectors, sink stall, back-to-back, input isolation, mid-run reset.
module tb_aes_128_seq;
   import aes_pkg::*;

   localparam block_t C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam block_t C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam block_t C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam block_t B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam block_t B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam block_t B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic   clk = 1'b0;
   logic   rst;
   int     total = 0;
   int     bad = 0;
   block_t exp_q[$];
   block_t exp_ct;

   aes_128_seq_if bus_if ();

   aes_128_seq dut (.clk(clk), .rst(rst), .bus(bus_if));

   always #5 clk = ~clk;

   // Output handshakes are seen half a cycle before the edge that completes them
   always @(negedge clk) begin
      if (!rst && bus_if.out_valid && bus_if.out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_unexpected: got %h, required no output", bus_if.out_bus);
         end else begin
            exp_ct = exp_q.pop_front();
            if (bus_if.out_bus !== exp_ct) begin
               bad++;
               $display("[TB] FAIL scoreboard_ct: got %h, required %h", bus_if.out_bus, exp_ct);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached before the summary, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input block_t pt, input block_t k, input logic v);
      bus_if.in_bus   = pt;
      bus_if.key      = k;
      bus_if.in_valid = v;
   endtask

   task automatic test_reset();
      rst              = 1'b1;
      bus_if.out_ready = 1'b0;
      drive('0, '0, 1'b0);
      step();
      step();
      total++;
      if (bus_if.in_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_in_ready: got %b, required 0", bus_if.in_ready);
      end
      total++;
      if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.out_bus !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got valid=%b busy=%b bus=%h, required 0 0 0",
                  bus_if.out_valid, bus_if.busy, bus_if.out_bus);
      end
      rst = 1'b0;
      #1;
      total++;
      if (bus_if.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL post_reset_in_ready: got %b, required 1", bus_if.in_ready);
      end
   endtask

   task automatic test_fips_c1();
      drive(C1_PT, C1_KEY, 1'b1);
      exp_q.push_back(C1_CT);
      step();
      drive('0, '0, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         total++;
         if (bus_if.busy !== 1'b1 || bus_if.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL c1_run_cycle%0d: got busy=%b valid=%b, required 1 0",
                     c, bus_if.busy, bus_if.out_valid);
         end
         step();
      end
      total++;
      if (bus_if.out_valid !== 1'b1 || bus_if.busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL c1_valid_cycle11: got valid=%b busy=%b, required 1 0",
                  bus_if.out_valid, bus_if.busy);
      end
      total++;
      if (bus_if.out_bus !== C1_CT) begin
         bad++;
         $display("[TB] FAIL c1_out_bus: got %h, required %h", bus_if.out_bus, C1_CT);
      end
      bus_if.out_ready = 1'b1;
      step();
      bus_if.out_ready = 1'b0;
      total++;
      if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL c1_after_handshake: got valid=%b in_ready=%b, required 0 1",
                  bus_if.out_valid, bus_if.in_ready);
      end
   endtask

   task automatic test_fips_b();
      int waited;
      drive(B_PT, B_KEY, 1'b1);
      exp_q.push_back(B_CT);
      step();
      drive('0, '0, 1'b0);
      waited = 1;
      while (bus_if.out_valid !== 1'b1 && waited < 30) begin
         step();
         waited++;
      end
      total++;
      if (waited != 11) begin
         bad++;
         $display("[TB] FAIL b_latency: got %0d cycles, required 11", waited);
      end
      total++;
      if (bus_if.out_bus !== B_CT) begin
         bad++;
         $display("[TB] FAIL b_out_bus: got %h, required %h", bus_if.out_bus, B_CT);
      end
      bus_if.out_ready = 1'b1;
      step();
      bus_if.out_ready = 1'b0;
   endtask

   task automatic test_sink_stall();
      int waited;
      drive(C1_PT, C1_KEY, 1'b1);
      exp_q.push_back(C1_CT);
      step();
      drive('0, '0, 1'b0);
      waited = 1;
      while (bus_if.out_valid !== 1'b1 && waited < 30) begin
         step();
         waited++;
      end
      total++;
      if (bus_if.out_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL stall_reach_done: got valid=%b after %0d cycles, required 1",
                  bus_if.out_valid, waited);
      end
      for (int c = 0; c < 20; c++) begin
         total++;
         if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 || bus_if.out_bus !== C1_CT) begin
            bad++;
            $display("[TB] FAIL stall_hold%0d: got valid=%b in_ready=%b bus=%h, required 1 0 %h",
                     c, bus_if.out_valid, bus_if.in_ready, bus_if.out_bus, C1_CT);
         end
         step();
      end
      bus_if.out_ready = 1'b1;
      #1;
      total++;
      if (bus_if.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL stall_release_ready: got %b, required 1", bus_if.in_ready);
      end
      step();
      bus_if.out_ready = 1'b0;
      total++;
      if (bus_if.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL stall_release_valid: got %b, required 0", bus_if.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      drive(C1_PT, C1_KEY, 1'b1);
      bus_if.out_ready = 1'b1;
      exp_q.push_back(C1_CT);
      step();
      drive(B_PT, B_KEY, 1'b1);
      exp_q.push_back(B_CT);
      for (int c = 1; c <= 10; c++) begin
         total++;
         if (bus_if.in_ready !== 1'b0 || bus_if.busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_first_run%0d: got in_ready=%b busy=%b, required 0 1",
                     c, bus_if.in_ready, bus_if.busy);
         end
         step();
      end
      total++;
      if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL b2b_first_done: got valid=%b in_ready=%b, required 1 1",
                  bus_if.out_valid, bus_if.in_ready);
      end
      step();
      drive('0, '0, 1'b0);
      total++;
      if (bus_if.busy !== 1'b1 || bus_if.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_second_accept: got busy=%b valid=%b, required 1 0",
                  bus_if.busy, bus_if.out_valid);
      end
      for (int c = 12; c <= 21; c++) begin
         total++;
         if (bus_if.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_second_run%0d: got valid=%b, required 0", c, bus_if.out_valid);
         end
         step();
      end
      total++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_bus !== B_CT) begin
         bad++;
         $display("[TB] FAIL b2b_second_valid: got valid=%b bus=%h, required 1 %h",
                  bus_if.out_valid, bus_if.out_bus, B_CT);
      end
      step();
      bus_if.out_ready = 1'b0;
   endtask

   task automatic test_input_isolation();
      drive(C1_PT, C1_KEY, 1'b1);
      exp_q.push_back(C1_CT);
      step();
      for (int c = 1; c <= 10; c++) begin
         drive({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
         total++;
         if (bus_if.in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL iso_no_accept%0d: got in_ready=%b, required 0", c, bus_if.in_ready);
         end
         step();
      end
      drive('0, '0, 1'b0);
      total++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_bus !== C1_CT) begin
         bad++;
         $display("[TB] FAIL iso_ct: got valid=%b bus=%h, required 1 %h",
                  bus_if.out_valid, bus_if.out_bus, C1_CT);
      end
      bus_if.out_ready = 1'b1;
      step();
      bus_if.out_ready = 1'b0;
      total++;
      if (bus_if.busy !== 1'b0 || bus_if.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL iso_idle_after: got busy=%b valid=%b, required 0 0",
                  bus_if.busy, bus_if.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      drive(C1_PT, C1_KEY, 1'b1);
      exp_q.push_back(C1_CT);
      step();
      drive('0, '0, 1'b0);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      #1;
      total++;
      if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midrst_idle: got in_ready=%b valid=%b busy=%b, required 1 0 0",
                  bus_if.in_ready, bus_if.out_valid, bus_if.busy);
      end
      drive(C1_PT, C1_KEY, 1'b1);
      exp_q.push_back(C1_CT);
      step();
      drive('0, '0, 1'b0);
      repeat (10) step();
      total++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_bus !== C1_CT) begin
         bad++;
         $display("[TB] FAIL midrst_fresh_ct: got valid=%b bus=%h, required 1 %h",
                  bus_if.out_valid, bus_if.out_bus, C1_CT);
      end
      bus_if.out_ready = 1'b1;
      step();
      bus_if.out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_sink_stall();
      test_back_to_back();
      test_input_isolation();
      test_reset_mid();
      step();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/aes_128_seq.md
# aes_128_seq

Iterative AES-128 encryption engine that computes one cipher round per clock instead of the fully unrolled combinational core. It accepts a plaintext/key pair over a valid/ready handshake, runs the initial AddRoundKey and ten rounds, then holds the ciphertext under a second valid/ready handshake. It reuses the existing sub_bytes, shift_rows, mix_columns and key_expansion blocks. It sits between a block-level DMA/stream front end and a ciphertext sink wherever area matters more than throughput.

## Interface
- No parameters. The block is AES-128 only; the round count is fixed in the package.
- clk  in  1  sole clock; all flops rise-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext/key pair present.
- in_ready  out  1  engine can accept a pair this cycle.
- in_bus  in  128  plaintext; byte 0 in [127:120].
- key  in  128  cipher key, same byte order.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  sink accepts ciphertext.
- out_bus  out  128  ciphertext, same byte order.
- busy  out  1  high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE, round counter rnd = 0, data register = 0, key register = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid: key_reg <= key, st <= in_bus ^ key, rnd <= 1, go to RUN.
- RUN:
  - Each cycle, st <= aes_round(st, rk[rnd]); rnd <= rnd + 1.
  - MixColumns is bypassed when rnd == 10.
  - After the rnd == 10 update, go to DONE and set rnd to 0.
- Round keys: key_expansion is driven from key_reg. rk[rnd] is a mux over its 11 outputs; rk[0] equals key_reg.
- DONE:
  - out_valid = 1 and out_bus = st.
  - out_bus stays stable until the handshake completes.
  - On out_ready, go to IDLE. If in_valid is also high, take the back-to-back path below instead.
- Back-to-back: in_ready = (IDLE) | (DONE & out_ready).
  - A pair accepted in DONE on the same cycle as the output handshake loads st, key_reg and rnd = 1, and goes directly to RUN.
- Inputs in_bus and key are sampled only on the accepting edge. Later changes have no effect on a block in flight.
- in_valid while in RUN is not accepted (in_ready = 0). The source holds its data per the valid/ready rule.
- out_valid never drops without out_ready once asserted, except on rst.
- rst mid-RUN or in DONE aborts the block and discards the ciphertext. The next cycle is IDLE with out_valid = 0 and in_ready = 1.
- All output and control signals are driven from registers or from FSM-state decode. There is no combinational path from in_valid to out_valid. out_ready goes to in_ready combinationally only.

## Timing
- Accept handshake in cycle 0. RUN occupies cycles 1-10. out_valid is high from cycle 11.
- Latency from accept to out_valid is 11 cycles.
- Throughput is one block per 11 cycles with an always-ready sink, via back-to-back accept in DONE.
- With a stalled sink, DONE holds indefinitely.
- Reset values: in_ready = 0 during rst and 1 the cycle after; out_valid = 0; busy = 0; out_bus = 0.
- The round counter is 4 bits and never exceeds 10. rnd == 0 is used only in IDLE/DONE.

## Structure
- The shared package aes_pkg holds:
  - AES_ROUNDS = 10;
  - the rnd_t typedef (logic [3:0]);
  - the enum seq_state_t {IDLE, RUN, DONE};
  - the block_t typedef (logic [127:0]).
- One new sub-module, aes_round:
  - ports: in_bus, round_key, last, out_bus;
  - function: sub_bytes -> shift_rows -> mix_columns (skipped when last) -> XOR round_key;
  - it instantiates the existing sub_bytes, shift_rows and mix_columns blocks.
- The top level holds the FSM, counter, st/key_reg registers, key_expansion instance and round-key mux.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff.
  - Required: out_valid in cycle 11 with out_bus 69c4e0d86a7b0430d8cdb78070b4c55a; busy high in cycles 1-10.
- FIPS-197 B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734.
  - Required: out_bus 3925841d02dc09fbdc118597196a0b32.
- Sink stall:
  - Stimulus: hold out_ready = 0 for 20 cycles after DONE.
  - Required: out_bus stable, out_valid stays 1, in_ready = 0. The handshake completes the cycle out_ready rises.
- Back-to-back:
  - Stimulus: vector C.1 then B, out_ready = 1, in_valid held.
  - Required: second accept on the same edge as the first output handshake. Second out_valid exactly 11 cycles after the first. Both ciphertexts correct.
- Input isolation:
  - Stimulus: change in_bus and key during RUN.
  - Required: ciphertext unchanged; no accept during RUN.
- Reset mid-operation:
  - Stimulus: assert rst in cycle 5 of RUN.
  - Required: next cycle IDLE with out_valid = 0 and in_ready = 1. A fresh C.1 block then produces the correct result at +11.
